// File: rtl/xge_wb_pkg.sv
// rtl/xge_wb_pkg.sv - shared types and sizing helpers for the Wishbone config arbiter
package xge_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wb_arb_state_t;

  localparam int ADR_W_DEF = 8;
  localparam int DAT_W_DEF = 32;

  localparam logic [DAT_W_DEF-1:0] TIMEOUT_RDATA = '0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A disabled timeout (0) still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/xge_rr_arbiter.sv
// rtl/xge_rr_arbiter.sv - combinational round-robin pick: first request after ptr, wrapping
module xge_rr_arbiter
  import xge_wb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to ptr+1 so the nearest hit is written last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        gnt_o = N'(1) << cand;
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xge_wb_cfg_arbiter.sv
// rtl/xge_wb_cfg_arbiter.sv - round-robin sharing of the MAC Wishbone slave port with bus timeout
module xge_wb_cfg_arbiter
  import xge_wb_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int TIMEOUT_CYCLES = 16,
  parameter  int ADR_W          = ADR_W_DEF,
  parameter  int DAT_W          = DAT_W_DEF,
  localparam int IW             = idx_width(NUM_REQ)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ*ADR_W-1:0] req_adr,
  input  logic [NUM_REQ*DAT_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_done,
  output logic                     req_err,
  output logic [DAT_W-1:0]         rsp_rdata,
  output logic                     busy,
  output logic [IW-1:0]            gnt_id,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [ADR_W-1:0]         wb_adr_o,
  output logic [DAT_W-1:0]         wb_dat_o,
  input  logic [DAT_W-1:0]         wb_dat_i,
  input  logic                     wb_ack_i
);

  localparam int               CW         = cnt_width(TIMEOUT_CYCLES);
  localparam bit               TO_EN      = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0]    CNT_LAST   = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [DAT_W-1:0] RDATA_NONE = DAT_W'(TIMEOUT_RDATA);

  wb_arb_state_t        state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        gnt_q;
  logic [NUM_REQ-1:0]   gnt_oh_q;
  logic                 we_q;
  logic [ADR_W-1:0]     adr_q;
  logic [DAT_W-1:0]     dat_q;
  logic [CW-1:0]        cnt_q;
  logic                 cyc_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [DAT_W-1:0]     rdata_q;
  logic                 err_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;

  logic                 sel_we_d;
  logic [ADR_W-1:0]     sel_adr_d;
  logic [DAT_W-1:0]     sel_dat_d;
  logic [CW-1:0]        cnt_d;
  logic                 timeout_hit;

  xge_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Grant is one-hot, so OR-ing the masked fields selects exactly the winner.
  always_comb begin
    sel_we_d  = 1'b0;
    sel_adr_d = '0;
    sel_dat_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_we_d  = sel_we_d  | req_we[i];
        sel_adr_d = sel_adr_d | req_adr[i*ADR_W +: ADR_W];
        sel_dat_d = sel_dat_d | req_wdata[i*DAT_W +: DAT_W];
      end
    end
  end

  assign cnt_d       = cnt_q + CW'(1);
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(NUM_REQ - 1);
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      cnt_q    <= '0;
      cyc_q    <= 1'b0;
      done_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q  <= BUS;
            cyc_q    <= 1'b1;
            ptr_q    <= arb_idx;
            gnt_q    <= arb_idx;
            gnt_oh_q <= arb_gnt;
            we_q     <= sel_we_d;
            adr_q    <= sel_adr_d;
            dat_q    <= sel_dat_d;
            cnt_q    <= '0;
          end
        end
        BUS: begin
          // An ack landing on the last allowed cycle still counts as success.
          if (wb_ack_i) begin
            state_q <= DONE;
            cyc_q   <= 1'b0;
            rdata_q <= we_q ? '0 : wb_dat_i;
            err_q   <= 1'b0;
            done_q  <= gnt_oh_q;
          end else if (timeout_hit) begin
            state_q <= DONE;
            cyc_q   <= 1'b0;
            rdata_q <= RDATA_NONE;
            err_q   <= 1'b1;
            done_q  <= gnt_oh_q;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign gnt_id    = gnt_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_xge_wb_cfg_arbiter.sv
// tb/tb_xge_wb_cfg_arbiter.sv - directed bench with a transaction-level reference model
module tb_xge_wb_cfg_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_adr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_done;
  logic            req_err;
  logic [DW-1:0]   rsp_rdata;
  logic            busy;
  logic [0:0]      gnt_id;
  logic            wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW-1:0]   wb_dat_i = '0;
  logic            wb_ack_i = 1'b0;

  xge_wb_cfg_arbiter #(
    .NUM_REQ(N), .TIMEOUT_CYCLES(TO), .ADR_W(AW), .DAT_W(DW)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid), .req_we(req_we), .req_adr(req_adr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .rsp_rdata(rsp_rdata), .busy(busy), .gnt_id(gnt_id),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave: acks on the ack_delay-th strobe cycle (0 = never); stray drives ack while idle.
  int          ack_delay = 1;
  bit          stray = 0;
  logic [DW-1:0] slave_rdata = '0;
  int          sl_cnt = 0;
  initial forever begin
    @(negedge wb_clk_i);
    wb_dat_i = slave_rdata;
    if (wb_stb_o) begin
      sl_cnt++;
      wb_ack_i = (ack_delay != 0 && sl_cnt == ack_delay);
    end else begin
      sl_cnt   = 0;
      wb_ack_i = stray;
    end
  end

  // Reference model: phase 0 free, 1 on the bus, 2 reporting completion.
  int            m_phase = 0, m_last = N - 1, m_owner = 0, m_gnt = 0, m_beats = 0;
  logic          m_we = 0, m_err = 0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_dat = '0, m_rdata = '0;
  initial forever begin
    @(posedge wb_clk_i or posedge wb_rst_i);
    if (wb_rst_i) begin
      m_phase = 0; m_last = N - 1; m_owner = 0; m_gnt = 0; m_beats = 0;
      m_we = 0; m_err = 0; m_adr = '0; m_dat = '0; m_rdata = '0;
    end else if (m_phase == 0) begin
      bit found;
      int c;
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && req_valid[c]) begin
          found = 1; m_owner = c; m_gnt = c; m_last = c;
          m_we = req_we[c]; m_adr = req_adr[c*AW +: AW]; m_dat = req_wdata[c*DW +: DW];
          m_beats = 0; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_beats++;
      if (wb_ack_i) begin
        m_rdata = m_we ? '0 : wb_dat_i; m_err = 0; m_phase = 2;
      end else if (m_beats == TO) begin
        m_rdata = '0; m_err = 1; m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Monitor logs plus per-cycle comparison against the model.
  int            cyc_n = 0, cur_len = 0;
  bit            prev_stb = 0;
  int            grant_q[$], done_id_q[$], done_len_q[$], done_cyc_q[$], done_err_q[$];
  logic [DW-1:0] done_rdata_q[$];
  logic          first_we;
  logic [AW-1:0] first_adr;
  initial forever begin
    @(negedge wb_clk_i);
    cyc_n++;
    if (wb_stb_o) begin
      if (!prev_stb) begin
        grant_q.push_back(int'(gnt_id));
        first_we  = wb_we_o;
        first_adr = wb_adr_o;
        cur_len   = 0;
      end
      cur_len++;
    end
    prev_stb = wb_stb_o;
    if (req_done != '0) begin
      done_id_q.push_back(req_done[1] ? 1 : 0);
      done_len_q.push_back(cur_len);
      done_cyc_q.push_back(cyc_n);
      done_err_q.push_back(int'(req_err));
      done_rdata_q.push_back(rsp_rdata);
    end
    if (cmp_en) begin
      chk("busy", busy, m_phase != 0);
      chk("cyc", wb_cyc_o, m_phase == 1);
      chk("stb", wb_stb_o, m_phase == 1);
      chk("done", req_done, (m_phase == 2) ? (1 << m_owner) : 0);
      chk("gnt_id", gnt_id, m_gnt);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("req_err", req_err, m_err);
      if (m_phase == 1) begin
        chk("wb_we", wb_we_o, m_we);
        chk("wb_adr", wb_adr_o, m_adr);
        chk("wb_dat", wb_dat_o, m_dat);
      end
    end
  end

  task automatic set_req(input int id, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    req_we[id] = we;
    req_adr[id*AW +: AW] = adr;
    req_wdata[id*DW +: DW] = dat;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_done(input int id, input string tag);
    int n;
    n = 0;
    while (!req_done[id] && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk({tag, "_done_seen"}, req_done[id], 1);
    req_valid[id] = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge wb_clk_i);
    #1;
  endtask

  initial begin
    int d0, g0, n;
    #1 wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", req_done, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", req_err, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    cmp_en = 1;

    // Single write, ack on the 2nd bus cycle
    d0 = done_id_q.size();
    ack_delay = 2;
    set_req(0, 1'b1, 8'h00, 32'h0000_0001);
    wait_done(0, "t1");
    settle();
    chk("t1_done_count", done_id_q.size() - d0, 1);
    chk("t1_id", done_id_q[$], 0);
    chk("t1_we", first_we, 1);
    chk("t1_adr", first_adr, 8'h00);
    chk("t1_len", done_len_q[$], 2);
    chk("t1_err", done_err_q[$], 0);
    chk("t1_rdata", done_rdata_q[$], 0);

    // Read by requester 1
    ack_delay = 1;
    slave_rdata = 32'hCAFE_F00D;
    set_req(1, 1'b0, 8'h08, 32'h0);
    wait_done(1, "t2");
    settle();
    chk("t2_id", done_id_q[$], 1);
    chk("t2_rdata", done_rdata_q[$], 32'hCAFE_F00D);
    chk("t2_we", first_we, 0);
    chk("t2_adr", first_adr, 8'h08);
    chk("t2_hold", rsp_rdata, 32'hCAFE_F00D);

    // Contention over six transactions
    g0 = grant_q.size();
    d0 = done_cyc_q.size();
    set_req(0, 1'b0, 8'h10, 32'h0);
    set_req(1, 1'b1, 8'h14, 32'hA5A5_A5A5);
    n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(negedge wb_clk_i);
      if (req_done != '0) n++;
    end
    req_valid = '0;
    settle();
    chk("t3_txn_count", n, 6);
    chk("t3_grants", grant_q.size() - g0, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_order%0d", i), grant_q[g0 + i], i % 2);
      chk($sformatf("t3_len%0d", i), done_len_q[d0 + i], 1);
    end
    for (int i = 1; i < 6; i++)
      chk($sformatf("t3_spacing%0d", i), done_cyc_q[d0 + i] - done_cyc_q[d0 + i - 1], 3);

    // Timeout with no ack, then ack on the final allowed cycle
    ack_delay = 0;
    slave_rdata = 32'hDEAD_BEEF;
    set_req(0, 1'b0, 8'h20, 32'h0);
    wait_done(0, "t4a");
    #1;
    chk("t4a_err_out", req_err, 1);
    chk("t4a_rdata_out", rsp_rdata, 0);
    settle();
    chk("t4a_len", done_len_q[$], 16);
    chk("t4a_err", done_err_q[$], 1);
    ack_delay = 16;
    slave_rdata = 32'h1234_5678;
    set_req(0, 1'b0, 8'h24, 32'h0);
    wait_done(0, "t4b");
    settle();
    chk("t4b_len", done_len_q[$], 16);
    chk("t4b_err", done_err_q[$], 0);
    chk("t4b_rdata", done_rdata_q[$], 32'h1234_5678);

    // Stray ack while idle
    d0 = done_id_q.size();
    stray = 1;
    repeat (3) @(negedge wb_clk_i);
    stray = 0;
    settle();
    chk("stray_no_done", done_id_q.size() - d0, 0);
    chk("stray_idle", busy, 0);

    // Reset during the 3rd bus cycle
    d0 = done_id_q.size();
    g0 = grant_q.size();
    ack_delay = 0;
    set_req(1, 1'b0, 8'h30, 32'h0);
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      @(negedge wb_clk_i);
      if (wb_stb_o) n++;
    end
    chk("t5_reached_bus3", n, 3);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("t5_cyc_async", wb_cyc_o, 0);
    chk("t5_stb_async", wb_stb_o, 0);
    chk("t5_busy_async", busy, 0);
    @(negedge wb_clk_i);
    ack_delay = 1;
    wb_rst_i = 1'b0;
    wait_done(1, "t5");
    settle();
    chk("t5_done_count", done_id_q.size() - d0, 1);
    chk("t5_grant_count", grant_q.size() - g0, 2);
    chk("t5_regrant", grant_q[$], 1);

    // Requester withdraws mid-transaction
    d0 = done_id_q.size();
    g0 = grant_q.size();
    ack_delay = 3;
    set_req(0, 1'b0, 8'h40, 32'h0);
    for (int c = 0; c < 50 && !wb_stb_o; c++) @(negedge wb_clk_i);
    chk("t6_on_bus", wb_stb_o, 1);
    req_valid[0] = 1'b0;
    n = 0;
    while (!req_done[0] && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("t6_done_pulse", req_done, 2'b01);
    repeat (10) @(negedge wb_clk_i);
    #1;
    chk("t6_done_count", done_id_q.size() - d0, 1);
    chk("t6_no_regrant", grant_q.size() - g0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
